// File: rtl/disp_pkg.sv
// Shared types, segment codes and helpers for the add/sub display front end.
package disp_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  // Segments are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Number of decimal digits needed to print 2**w.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = 64'd1 << w;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one LOAD cycle, W+1 SHIFT cycles, one DONE cycle.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int W    = 8,
  parameter int NDIG = 4
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    start,
  input  logic [W:0]              bin,
  output logic                    load,
  output logic                    busy,
  output logic                    done,
  output logic [4*(NDIG-1)-1:0]   bcd
);

  localparam int BW = 4 * (NDIG - 1);
  localparam int CW = $clog2(W + 1);

  state_e        state_q, state_d;
  logic [W:0]    sh_q, sh_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NDIG - 1; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        sh_d    = bin;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = {adj[BW-2:0], sh_q[W]};
        sh_d  = {sh_q[W-1:0], 1'b0};
        if (cnt_q == CW'(W)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load = (state_q == LOAD);
  assign busy = (state_q == LOAD) || (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/addsub_disp_mux_n.sv
// Signed A+/-B shown on an NDIG-digit multiplexed common-anode display
// with leading-zero blanking and a floating minus sign.
module addsub_disp_mux_n
  import disp_pkg::*;
#(
  parameter int W       = 8,
  parameter int NDIG    = 4,
  parameter int DIV     = 25000,
  parameter int HOLD_EN = 1
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  input  logic            SUB,
  input  logic            HOLD,
  output logic [6:0]      SEG,
  output logic [NDIG-1:0] AN,
  output logic            VALID,
  output logic            BUSY
);

  localparam int BW = 4 * (NDIG - 1);
  localparam int TW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);

  if (NDIG - 1 < dec_digits(W)) begin : g_ndig_chk
    $error("addsub_disp_mux_n: NDIG too small for W");
  end
  if (DIV < 2) begin : g_div_chk
    $error("addsub_disp_mux_n: DIV must be at least 2");
  end

  // Sign-extended to W+1 bits so the result never overflows; -2**W still fits as a magnitude.
  logic [W:0] a_x, b_x, r, mag;
  assign a_x = {A[W-1], A};
  assign b_x = {B[W-1], B};
  assign r   = SUB ? (a_x - b_x) : (a_x + b_x);
  assign mag = r[W] ? (~r + 1'b1) : r;

  logic          start, load, done;
  logic [BW-1:0] bcd;
  assign start = !((HOLD_EN != 0) && HOLD);

  bin2bcd_seq #(.W(W), .NDIG(NDIG)) u_b2b (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .start (start),
    .bin   (mag),
    .load  (load),
    .busy  (BUSY),
    .done  (done),
    .bcd   (bcd)
  );

  logic          sign_q, dsign_q, valid_q;
  logic [BW-1:0] disp_q;
  logic [TW-1:0] tick_q;
  logic [IW-1:0] idx_q, k;
  logic [3:0]    dig;
  logic [6:0]    seg_d, seg_q;
  logic [NDIG-1:0] an_d, an_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sign_q  <= 1'b0;
      dsign_q <= 1'b0;
      valid_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      if (load) sign_q <= r[W];
      if (done) begin
        disp_q  <= bcd;
        dsign_q <= sign_q;
        valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tick_q <= '0;
      idx_q  <= '0;
    end else if (tick_q == TW'(DIV - 1)) begin
      tick_q <= '0;
      idx_q  <= (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  // k: most significant nonzero BCD digit (0 for a zero value).
  always_comb begin
    k = '0;
    for (int i = 0; i < NDIG - 1; i++)
      if (disp_q[4*i +: 4] != 4'd0) k = IW'(i);
    dig = 4'd0;
    for (int i = 0; i < NDIG - 1; i++)
      if (idx_q == IW'(i)) dig = disp_q[4*i +: 4];
    seg_d = SEG_BLANK;
    if (valid_q) begin
      if (idx_q <= k)                            seg_d = hex7(dig);
      else if (dsign_q && (idx_q == k + IW'(1))) seg_d = SEG_MINUS;
    end
    an_d = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_q);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_addsub_disp_mux_n.sv
// Randomised and directed checks of the add/sub display against a decimal model.
module tb_addsub_disp_mux_n;

  localparam int W    = 8;
  localparam int NDIG = 4;
  localparam int DIV  = 4;
  localparam int SETTLE = 2 * (W + 3) + 2;

  logic            CLK = 1'b0;
  logic            RSTn;
  logic [W-1:0]    A, B;
  logic            SUB, HOLD;
  logic [6:0]      SEG;
  logic [NDIG-1:0] AN;
  logic            VALID, BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] got_seg [NDIG];
  bit         seen    [NDIG];
  logic [6:0] glyph   [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 CLK = ~CLK;

  addsub_disp_mux_n #(.W(W), .NDIG(NDIG), .DIV(DIV), .HOLD_EN(1)) dut (
    .CLK(CLK), .RSTn(RSTn), .A(A), .B(B), .SUB(SUB), .HOLD(HOLD),
    .SEG(SEG), .AN(AN), .VALID(VALID), .BUSY(BUSY)
  );

  // Expected pattern for display digit i when the shown value is v.
  function automatic logic [6:0] ref_seg(input int v, input int i);
    int mag, n, t, d;
    mag = (v < 0) ? -v : v;
    n = 1;
    t = mag / 10;
    while (t != 0) begin
      n++;
      t = t / 10;
    end
    if (i < n) begin
      d = mag;
      for (int j = 0; j < i; j++) d = d / 10;
      return glyph[d % 10];
    end
    if (i == n && v < 0) return 7'b0111111;
    return 7'h7F;
  endfunction

  function automatic int ref_val();
    int a, b;
    a = int'($signed(A));
    b = int'($signed(B));
    return SUB ? (a - b) : (a + b);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic read_display();
    logic [NDIG-1:0] sel;
    for (int i = 0; i < NDIG; i++) seen[i] = 1'b0;
    repeat (2 * NDIG * DIV) begin
      @(negedge CLK);
      for (int i = 0; i < NDIG; i++) begin
        sel = ~(NDIG'(1) << i);
        if (AN === sel) begin
          got_seg[i] = SEG;
          seen[i]    = 1'b1;
        end
      end
    end
  endtask

  task automatic check_display(input int v, input string name);
    logic [6:0] exp_s;
    read_display();
    for (int i = 0; i < NDIG; i++) begin
      exp_s = ref_seg(v, i);
      n_checks++;
      if (!seen[i] || got_seg[i] !== exp_s)
        $display("FAIL %s digit%0d: got %h (seen=%0d) expected %h (value %0d)",
                 name, i, got_seg[i], seen[i], exp_s, v);
      else n_pass++;
    end
  endtask

  task automatic check_valid(input logic exp_v, input string name);
    n_checks++;
    if (VALID !== exp_v) $display("FAIL %s VALID: got %b expected %b", name, VALID, exp_v);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (SEG !== 7'h7F) $display("FAIL %s SEG: got %h expected 7f", name, SEG);
    else n_pass++;
    n_checks++;
    if (AN !== {NDIG{1'b1}}) $display("FAIL %s AN: got %b expected all ones", name, AN);
    else n_pass++;
    check_valid(1'b0, name);
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL %s BUSY: got %b expected 0", name, BUSY);
    else n_pass++;
  endtask

  task automatic apply(input int a, input int b, input logic s);
    A   = W'(a);
    B   = W'(b);
    SUB = s;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    HOLD = 1'b0;
    apply(5, 3, 1'b0);
    wait_cycles(3);
    check_reset_outputs("reset");
    RSTn = 1'b1;
  endtask

  task automatic test_basic();
    wait_cycles(2 * (W + 3));
    check_valid(1'b1, "basic");
    check_display(8, "basic_5p3");
  endtask

  task automatic test_directed();
    int ta [4] = '{-128, 127, 3, 0};
    int tb [4] = '{-128, -128, 10, 0};
    bit ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 4; t++) begin
      apply(ta[t], tb[t], ts[t]);
      wait_cycles(SETTLE);
      check_display(ref_val(), $sformatf("directed%0d", t));
    end
  endtask

  task automatic test_scan();
    logic [NDIG-1:0] exp_an;
    int guard;
    guard = 0;
    while (AN !== ~(NDIG'(1) << (NDIG - 1)) && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    while (AN !== ~NDIG'(1) && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      $display("FAIL scan_sync: AN never reached %b, last %b", ~NDIG'(1), AN);
      return;
    end
    for (int j = 0; j <= NDIG * DIV; j++) begin
      exp_an = ~(NDIG'(1) << ((j / DIV) % NDIG));
      n_checks++;
      if (AN !== exp_an) $display("FAIL scan step%0d AN: got %b expected %b", j, AN, exp_an);
      else n_pass++;
      @(negedge CLK);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      A   = W'($urandom);
      B   = W'($urandom);
      SUB = 1'($urandom);
      wait_cycles(SETTLE);
      check_display(ref_val(), $sformatf("random%0d", t));
    end
  endtask

  task automatic test_hold();
    int guard;
    apply(5, 3, 1'b0);
    wait_cycles(SETTLE);
    check_display(8, "hold_before");
    HOLD = 1'b1;
    guard = 0;
    while (BUSY !== 1'b0 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    apply(9, 3, 1'b0);
    wait_cycles(3 * (W + 3));
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL hold_idle BUSY: got %b expected 0", BUSY);
    else n_pass++;
    check_display(8, "hold_frozen");
    HOLD = 1'b0;
    wait_cycles(SETTLE);
    check_display(12, "hold_release");
  endtask

  task automatic test_reset_mid();
    int  guard;
    bit  early_valid;
    apply(-7, 100, 1'b0);
    guard = 0;
    while (BUSY !== 1'b0 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    while (BUSY !== 1'b1 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      $display("FAIL reset_mid_sync: BUSY never rose, last %b", BUSY);
      return;
    end
    wait_cycles(3);
    RSTn = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    wait_cycles(2);
    RSTn = 1'b1;
    early_valid = 1'b0;
    repeat (W + 3) begin
      @(negedge CLK);
      if (VALID !== 1'b0 || SEG !== 7'h7F) early_valid = 1'b1;
    end
    n_checks++;
    if (early_valid) $display("FAIL reset_mid_early: display got data before %0d cycles, expected blank", W + 3);
    else n_pass++;
    wait_cycles(SETTLE);
    check_valid(1'b1, "reset_mid_after");
    check_display(93, "reset_mid_after");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_scan();
    test_random();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
